// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding-select encodings
// and the default-width shadow-stage record.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam int unsigned STAGE_RA_W = 5;

  // Per-stage tracking record at the default register-index width
  typedef struct packed {
    logic                  valid;
    logic [STAGE_RA_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } stage_t;

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage: valid, destination index and write/load bits.
// A bubble loads an all-zero (invalid) record.
module hazard_stage_reg #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_bubble,
  input  logic                  i_valid,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_reg_write,
  input  logic                  i_mem_read,
  output logic                  o_valid,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic                  o_reg_write,
  output logic                  o_mem_read
);

  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_reg_write;
  logic                  r_mem_read;

  // Capture the upstream record, or clear it on reset / bubble
  always_ff @(posedge clk) begin
    if (rst || i_bubble) begin
      r_valid     <= 1'b0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else begin
      r_valid     <= i_valid;
      r_rd        <= i_rd;
      r_reg_write <= i_reg_write;
      r_mem_read  <= i_mem_read;
    end
  end

  assign o_valid     = r_valid;
  assign o_rd        = r_rd;
  assign o_reg_write = r_reg_write;
  assign o_mem_read  = r_mem_read;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard unit beside ID: shadows EX/MEM/WB control bits and drives stall,
// flush and forwarding selects, plus saturating stall/flush counters.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_is_branch,
  input  logic                  id_branch_taken,
  input  logic                  id_jump,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic                  flush_if_id,
  output logic [1:0]            fwd_ex_a,
  output logic [1:0]            fwd_ex_b,
  output logic                  fwd_id_a,
  output logic                  fwd_id_b,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  logic                  w_ex_valid,  w_mem_valid,  w_wb_valid;
  logic [REG_ADDR_W-1:0] w_ex_rd,     w_mem_rd,     w_wb_rd;
  logic                  w_ex_rw,     w_mem_rw,     w_wb_rw;
  logic                  w_ex_mr,     w_mem_mr,     w_wb_mr;
  logic                  w_ex_in_bubble;
  logic                  w_unused_wb_mr;

  logic [REG_ADDR_W-1:0] r_ex_rs1, r_ex_rs2;
  logic                  r_ex_uses_rs1, r_ex_uses_rs2;
  logic [CNT_W-1:0]      r_stall_cnt, r_flush_cnt;

  logic w_ex_hit, w_mem_hit, w_stall, w_flush;

  // A stage writes r only when it is a valid register write to a non-x0 index
  function automatic logic writes(input logic v, input logic rw,
                                  input logic [REG_ADDR_W-1:0] rd,
                                  input logic [REG_ADDR_W-1:0] r);
    return v && rw && (rd == r) && (rd != '0);
  endfunction

  assign w_ex_in_bubble = id_ex_bubble || !id_valid;
  assign w_unused_wb_mr = w_wb_mr;

  hazard_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_ex (
    .clk(clk), .rst(rst), .i_bubble(w_ex_in_bubble),
    .i_valid(id_valid), .i_rd(id_rd), .i_reg_write(id_reg_write), .i_mem_read(id_mem_read),
    .o_valid(w_ex_valid), .o_rd(w_ex_rd), .o_reg_write(w_ex_rw), .o_mem_read(w_ex_mr)
  );

  hazard_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_mem (
    .clk(clk), .rst(rst), .i_bubble(1'b0),
    .i_valid(w_ex_valid), .i_rd(w_ex_rd), .i_reg_write(w_ex_rw), .i_mem_read(w_ex_mr),
    .o_valid(w_mem_valid), .o_rd(w_mem_rd), .o_reg_write(w_mem_rw), .o_mem_read(w_mem_mr)
  );

  hazard_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_wb (
    .clk(clk), .rst(rst), .i_bubble(1'b0),
    .i_valid(w_mem_valid), .i_rd(w_mem_rd), .i_reg_write(w_mem_rw), .i_mem_read(w_mem_mr),
    .o_valid(w_wb_valid), .o_rd(w_wb_rd), .o_reg_write(w_wb_rw), .o_mem_read(w_wb_mr)
  );

  // EX-only source tracking, cleared alongside the EX shadow record
  always_ff @(posedge clk) begin
    if (rst || w_ex_in_bubble) begin
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_uses_rs1 <= 1'b0;
      r_ex_uses_rs2 <= 1'b0;
    end else begin
      r_ex_rs1      <= id_rs1;
      r_ex_rs2      <= id_rs2;
      r_ex_uses_rs1 <= id_uses_rs1;
      r_ex_uses_rs2 <= id_uses_rs2;
    end
  end

  // Stall/flush detection against the ID instruction's used sources
  always_comb begin
    w_ex_hit  = (id_uses_rs1 && writes(w_ex_valid, w_ex_rw, w_ex_rd, id_rs1)) ||
                (id_uses_rs2 && writes(w_ex_valid, w_ex_rw, w_ex_rd, id_rs2));
    w_mem_hit = (id_uses_rs1 && writes(w_mem_valid, w_mem_rw, w_mem_rd, id_rs1)) ||
                (id_uses_rs2 && writes(w_mem_valid, w_mem_rw, w_mem_rd, id_rs2));
    w_stall   = id_valid && ((w_ex_mr && w_ex_hit) ||
                             (id_is_branch && (w_ex_hit || (w_mem_mr && w_mem_hit))));
    w_flush   = id_valid && !w_stall && ((id_is_branch && id_branch_taken) || id_jump);
  end

  // Steering and forwarding outputs; reset forces the safe hold-and-bubble state
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b1;
    flush_if_id  = 1'b0;
    fwd_ex_a     = FWD_NONE;
    fwd_ex_b     = FWD_NONE;
    fwd_id_a     = 1'b0;
    fwd_id_b     = 1'b0;
    if (!rst) begin
      pc_write     = !w_stall;
      if_id_write  = !w_stall;
      id_ex_bubble = w_stall;
      flush_if_id  = w_flush;
      if (r_ex_uses_rs1 && writes(w_mem_valid, w_mem_rw, w_mem_rd, r_ex_rs1))
        fwd_ex_a = FWD_MEM;
      else if (r_ex_uses_rs1 && writes(w_wb_valid, w_wb_rw, w_wb_rd, r_ex_rs1))
        fwd_ex_a = FWD_WB;
      if (r_ex_uses_rs2 && writes(w_mem_valid, w_mem_rw, w_mem_rd, r_ex_rs2))
        fwd_ex_b = FWD_MEM;
      else if (r_ex_uses_rs2 && writes(w_wb_valid, w_wb_rw, w_wb_rd, r_ex_rs2))
        fwd_ex_b = FWD_WB;
      fwd_id_a = id_uses_rs1 && !w_mem_mr && writes(w_mem_valid, w_mem_rw, w_mem_rd, id_rs1);
      fwd_id_b = id_uses_rs2 && !w_mem_mr && writes(w_mem_valid, w_mem_rw, w_mem_rd, id_rs2);
    end
  end

  // Saturating performance counters, updated at the end of the counted cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit: each cycle drives one ID
// instruction, queues the expected steering outputs, and compares them
// mid-cycle. Counters use a 3-bit width so saturation is reachable.
module tb_pipeline_hazard_unit;

  localparam int unsigned W  = 5;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [W-1:0]  id_rs1, id_rs2, id_rd;
  logic          id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
  logic          id_is_branch, id_branch_taken, id_jump;
  logic          pc_write, if_id_write, id_ex_bubble, flush_if_id;
  logic [1:0]    fwd_ex_a, fwd_ex_b;
  logic          fwd_id_a, fwd_id_b;
  logic [CW-1:0] stall_count, flush_count;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.REG_ADDR_W(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken), .id_jump(id_jump),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .flush_if_id(flush_if_id), .fwd_ex_a(fwd_ex_a), .fwd_ex_b(fwd_ex_b),
    .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  typedef struct packed {
    logic       pcw;
    logic       bub;
    logic       fl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       ia;
    logic       ib;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t D, S, F;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t mk(input logic pcw, input logic bub, input logic fl,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic ia, input logic ib);
    exp_t e;
    e.pcw = pcw; e.bub = bub; e.fl = fl; e.fa = fa; e.fb = fb; e.ia = ia; e.ib = ib;
    return e;
  endfunction

  // One cycle: drive ID, queue expectation, compare at the falling edge
  task automatic cyc(input string tag, input logic r, input logic v,
                     input logic [W-1:0] rs1, input logic u1,
                     input logic [W-1:0] rs2, input logic u2,
                     input logic [W-1:0] rd, input logic rw, input logic mr,
                     input logic br, input logic tk, input logic jp, input exp_t e);
    exp_t x;
    rst = r; id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    id_is_branch = br; id_branch_taken = tk; id_jump = jp;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check_eq({tag, ".pc_write"},    32'(pc_write),     32'(x.pcw));
      check_eq({tag, ".if_id_write"}, 32'(if_id_write),  32'(x.pcw));
      check_eq({tag, ".bubble"},      32'(id_ex_bubble), 32'(x.bub));
      check_eq({tag, ".flush"},       32'(flush_if_id),  32'(x.fl));
      check_eq({tag, ".fwd_ex_a"},    32'(fwd_ex_a),     32'(x.fa));
      check_eq({tag, ".fwd_ex_b"},    32'(fwd_ex_b),     32'(x.fb));
      check_eq({tag, ".fwd_id_a"},    32'(fwd_id_a),     32'(x.ia));
      check_eq({tag, ".fwd_id_b"},    32'(fwd_id_b),     32'(x.ib));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input string tag, input exp_t e);
    cyc(tag, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3; i++) nop(tag, D);
  endtask

  task automatic check_cnt(input string tag, input int sc, input int fc);
    check_eq({tag, ".stall_count"}, 32'(stall_count), 32'(sc));
    check_eq({tag, ".flush_count"}, 32'(flush_count), 32'(fc));
  endtask

  initial begin
    D = mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    S = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    F = mk(1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);

    // Reset with a jump sitting in ID: flush and enables stay suppressed
    cyc("rst_a", 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, S);
    cyc("rst_b", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S);
    check_cnt("rst", 0, 0);

    // Load-use: lw x5 ; add x6,x5,x1
    cyc("lu_lw",    0, 1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, D);
    cyc("lu_stall", 0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, S);
    cyc("lu_go",    0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, D);
    nop("lu_fwd", mk(1, 0, 0, 2'b01, 2'b00, 0, 0));
    check_cnt("lu", 1, 0);
    drain("lu_drain");

    // Back-to-back ALU: add x3,x1,x2 ; sub x4,x3,x3
    cyc("alu_add", 0, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, D);
    cyc("alu_sub", 0, 1, 3, 1, 3, 1, 4, 1, 0, 0, 0, 0, D);
    nop("alu_fwd", mk(1, 0, 0, 2'b10, 2'b10, 0, 0));
    drain("alu_drain");

    // Double match on x7 (MEM wins) and MEM->ID forwarding of an ALU result
    cyc("dm_a",   0, 1, 0, 1, 0, 0, 7, 1, 0, 0, 0, 0, D);
    cyc("dm_b",   0, 1, 0, 1, 0, 0, 7, 1, 0, 0, 0, 0, D);
    cyc("dm_use", 0, 1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 0, mk(1, 0, 0, 2'b00, 2'b00, 1, 0));
    nop("dm_fwd", mk(1, 0, 0, 2'b10, 2'b00, 0, 0));
    drain("dm_drain");

    // Branch after load: lw x2 ; beq x2,x0 taken -> 2 stalls then flush
    cyc("bl_lw",  0, 1, 1, 1, 0, 0, 2, 1, 1, 0, 0, 0, D);
    cyc("bl_st1", 0, 1, 2, 1, 0, 1, 0, 0, 0, 1, 1, 0, S);
    cyc("bl_st2", 0, 1, 2, 1, 0, 1, 0, 0, 0, 1, 1, 0, S);
    cyc("bl_fl",  0, 1, 2, 1, 0, 1, 0, 0, 0, 1, 1, 0, F);
    nop("bl_after", D);
    check_cnt("bl", 3, 1);
    drain("bl_drain");

    // x0 destination never creates a dependence; jal flushes immediately
    cyc("x0_addi", 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, D);
    cyc("x0_beq",  0, 1, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, D);
    cyc("x0_add",  0, 1, 0, 1, 0, 1, 9, 1, 0, 0, 0, 0, D);
    cyc("jal",     0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, F);
    nop("jal_after", D);
    check_cnt("jal", 3, 2);
    drain("jal_drain");

    // Stall and jump together: stall first, flush on the following cycle
    cyc("sj_lw",   0, 1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, D);
    cyc("sj_stall",0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, S);
    cyc("sj_fl",   0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, F);
    nop("sj_fwd", mk(1, 0, 0, 2'b01, 2'b00, 0, 0));
    check_cnt("sj", 4, 3);
    drain("sj_drain");

    // Reset during a stall discards tracking and clears the counters
    cyc("rs_lw",  0, 1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, D);
    cyc("rs_rst", 1, 1, 5, 1, 0, 1, 0, 0, 0, 1, 1, 0, S);
    check_cnt("rs_cleared", 0, 0);
    cyc("rs_go",  0, 1, 5, 1, 0, 1, 0, 0, 0, 1, 1, 0, F);
    nop("rs_after", D);
    check_cnt("rs", 0, 1);

    // Ten load-use stalls saturate the 3-bit stall counter at 7
    for (int i = 0; i < 10; i++) begin
      cyc("sat_lw",    0, 1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, D);
      cyc("sat_stall", 0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, S);
      cyc("sat_go",    0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, D);
      nop("sat_fwd", mk(1, 0, 0, 2'b01, 2'b00, 0, 0));
    end
    check_cnt("sat", 7, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
